// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types and defaults for the round-robin bus arbiter
package rr_arb_pkg;

  localparam int DW_DEF        = 16;
  localparam int MAX_BURST_DEF = 4;
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_bus_arbiter_if.sv
// rtl/rr_bus_arbiter_if.sv - requester, output and grant signals of the arbiter
interface rr_bus_arbiter_if
  import rr_arb_pkg::*;
#(
  parameter int DW = DW_DEF
);

  logic          req0_valid;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_src;
  logic          out_ready;
  logic          grant;

  // master: producers plus consumer side; slave: the arbiter itself
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, out_ready,
    input  req0_ready, req1_ready, out_valid, out_data, out_src, grant
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_src, grant
  );

endinterface

// File: rtl/rr_grant_fsm.sv
// rtl/rr_grant_fsm.sv - grant state machine, round-robin pointer and burst counter
module rr_grant_fsm
  import rr_arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0_valid,
  input  logic req1_valid,
  input  logic out_valid,
  input  logic out_ready,
  output logic req0_ready,
  output logic req1_ready,
  output logic grant
);

  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST);

  arb_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic             last, last_nx;
  logic             can_load, cur, own_valid, other_valid;

  assign can_load = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      last  <= last_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    last_nx     = last;
    cnt_inc     = cnt + 1'b1;
    cur         = (state == GRANT1);
    own_valid   = cur ? req1_valid : req0_valid;
    other_valid = cur ? req0_valid : req1_valid;
    req0_ready  = (state == GRANT0) && can_load;
    req1_ready  = (state == GRANT1) && can_load;
    grant       = (state == GRANT1);

    // Everything is frozen while the output register cannot take a word.
    if (can_load) begin
      case (state)
        IDLE: begin
          if (req0_valid && req1_valid) begin
            state_nx = last ? GRANT0 : GRANT1;
          end else if (req0_valid) begin
            state_nx = GRANT0;
          end else if (req1_valid) begin
            state_nx = GRANT1;
          end
        end
        GRANT0, GRANT1: begin
          if (!own_valid || (cnt_inc == BURST_LAST && other_valid)) begin
            last_nx  = cur;
            cnt_nx   = '0;
            state_nx = other_valid ? (cur ? GRANT0 : GRANT1) : IDLE;
          end else if (cnt_inc == BURST_LAST) begin
            cnt_nx = '0;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// rtl/rr_bus_arbiter.sv - two-requester round-robin arbiter with registered output stage
module rr_bus_arbiter
  import rr_arb_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  rr_bus_arbiter_if.slave bus
);

  logic          ready0, ready1, grant_sel, beat;
  logic [DW-1:0] sel_data;
  logic          out_valid_q, out_src_q;
  logic [DW-1:0] out_data_q;

  rr_grant_fsm #(
    .MAX_BURST (MAX_BURST)
  ) u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (bus.req0_valid),
    .req1_valid (bus.req1_valid),
    .out_valid  (out_valid_q),
    .out_ready  (bus.out_ready),
    .req0_ready (ready0),
    .req1_ready (ready1),
    .grant      (grant_sel)
  );

  assign beat     = (bus.req0_valid && ready0) || (bus.req1_valid && ready1);
  assign sel_data = grant_sel ? bus.req1_data : bus.req0_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
    end else if (beat) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
      out_src_q   <= grant_sel;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.grant      = grant_sel;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_src    = out_src_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb/tb_rr_bus_arbiter.sv - vector table, corner sequences and randomized model check
module tb_rr_bus_arbiter;

  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rr_bus_arbiter_if #(.DW(16)) bus ();

  rr_bus_arbiter #(
    .DW        (16),
    .MAX_BURST (MB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        v0, v1;
    logic [15:0] d0, d1;
    logic        ordy;
    logic        r0, r1, g, ov, os;
    logic [15:0] od;
  } vec_t;

  vec_t tbl[13];

  // reference model state: owner -1 means nobody holds the path
  int          m_owner, m_run, m_last, o;
  bit          m_ov, m_os, can_load, beat, er0, er1, eg;
  logic [15:0] m_od;
  bit          pv[2];
  logic [15:0] dw[2];
  logic [15:0] held;
  logic [15:0] got_q[$];
  int          idx, got, first_c, last_c;

  function automatic vec_t mk(logic v0, logic v1, logic [15:0] d0, logic [15:0] d1, logic ordy,
                              logic r0, logic r1, logic g, logic ov, logic os, logic [15:0] od);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.d0 = d0; v.d1 = d1; v.ordy = ordy;
    v.r0 = r0; v.r1 = r1; v.g = g; v.ov = ov; v.os = os; v.od = od;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {11'd0, bus.req0_ready, bus.req1_ready, bus.grant, bus.out_valid, bus.out_src, bus.out_data};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_data = '0;    bus.req1_data = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_owner = -1; m_run = 0; m_last = 1; m_ov = 0; m_os = 0; m_od = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = mk(1,1,16'h1000,16'h2000,1, 0,0,0,0,0,16'h0000);
    tbl[1]  = mk(1,1,16'h1000,16'h2000,1, 1,0,0,0,0,16'h0000);
    tbl[2]  = mk(1,1,16'h1001,16'h2000,1, 1,0,0,1,0,16'h1000);
    tbl[3]  = mk(1,1,16'h1002,16'h2000,1, 1,0,0,1,0,16'h1001);
    tbl[4]  = mk(1,1,16'h1003,16'h2000,1, 1,0,0,1,0,16'h1002);
    tbl[5]  = mk(1,1,16'h1004,16'h2000,1, 0,1,1,1,0,16'h1003);
    tbl[6]  = mk(1,1,16'h1004,16'h2001,1, 0,1,1,1,1,16'h2000);
    tbl[7]  = mk(1,1,16'h1004,16'h2002,1, 0,1,1,1,1,16'h2001);
    tbl[8]  = mk(1,1,16'h1004,16'h2003,1, 0,1,1,1,1,16'h2002);
    tbl[9]  = mk(1,1,16'h1004,16'h2004,1, 1,0,0,1,1,16'h2003);
    tbl[10] = mk(1,1,16'h1005,16'h2004,1, 1,0,0,1,0,16'h1004);
    tbl[11] = mk(1,1,16'h1006,16'h2004,0, 0,0,0,1,0,16'h1005);
    tbl[12] = mk(1,1,16'h1006,16'h2004,1, 1,0,0,1,0,16'h1005);

    // reset state, with inputs asserted to show readies stay low
    rst_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    bus.req0_data = 16'hFFFF; bus.req1_data = 16'hFFFF; bus.out_ready = 1'b1;
    @(negedge clk);
    chk("reset_state", outs(), 32'd0);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      bus.req0_valid = tbl[i].v0; bus.req1_valid = tbl[i].v1;
      bus.req0_data  = tbl[i].d0; bus.req1_data  = tbl[i].d1;
      bus.out_ready  = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d", i), outs(),
          {11'd0, tbl[i].r0, tbl[i].r1, tbl[i].g, tbl[i].ov, tbl[i].os, tbl[i].od});
      next_cycle();
    end

    // req1 alone streams 10 words; the counter wraps without releasing
    do_reset();
    idx = 0; got = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 30 && got < 10; c++) begin
      bus.req1_valid = (idx < 10);
      bus.req1_data  = 16'h3000 + 16'(idx);
      @(negedge clk);
      if (c >= 1 && c <= 10) chk("solo_grant", {31'd0, bus.grant}, 32'd1);
      if (bus.out_valid) begin
        chk("solo_src", {31'd0, bus.out_src}, 32'd1);
        chk("solo_data", {16'd0, bus.out_data}, 32'h3000 + 32'(got));
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
      end
      if (bus.req1_valid && bus.req1_ready) idx++;
      next_cycle();
    end
    chk("solo_count", 32'(got), 32'd10);
    chk("solo_no_gap", 32'(last_c - first_c), 32'd9);

    // one word from req0, then it drops valid and req1 takes over
    do_reset();
    bus.req0_valid = 1; bus.req0_data = 16'hABCD;
    bus.req1_valid = 1; bus.req1_data = 16'h5000;
    @(negedge clk); next_cycle();
    @(negedge clk);
    chk("drop_r0_lat", {31'd0, bus.req0_ready}, 32'd1);
    next_cycle();
    bus.req0_valid = 0;
    @(negedge clk);
    chk("drop_first", {15'd0, bus.out_src, bus.out_data}, {15'd0, 1'b0, 16'hABCD});
    next_cycle();
    @(negedge clk);
    chk("drop_grant", {30'd0, bus.grant, bus.req1_ready}, 32'd3);
    next_cycle();
    @(negedge clk);
    chk("drop_second", {14'd0, bus.out_valid, bus.out_src, bus.out_data}, {14'd0, 2'b11, 16'h5000});
    next_cycle();

    // output stalled for 5 cycles in the middle of a stream
    do_reset();
    idx = 0; got_q.delete(); held = '0;
    for (int c = 0; c < 40 && got_q.size() < 8; c++) begin
      bus.req0_valid = (idx < 8);
      bus.req0_data  = 16'h4000 + 16'(idx);
      bus.out_ready  = !(c >= 4 && c < 9);
      @(negedge clk);
      if (c == 4) begin
        held = bus.out_data;
        chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      end
      if (c >= 4 && c < 9) begin
        chk("stall_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
        chk("stall_hold", {15'd0, bus.grant, bus.out_data}, {15'd0, 1'b0, held});
      end
      if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
      if (bus.req0_valid && bus.req0_ready) idx++;
      next_cycle();
    end
    chk("stall_count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < got_q.size(); i++)
      chk($sformatf("stall_word%0d", i), {16'd0, got_q[i]}, 32'h4000 + 32'(i));

    // asynchronous reset in GRANT1 with cnt=2 and a word held
    do_reset();
    bus.req1_valid = 1; bus.req1_data = 16'h6000;
    next_cycle(); next_cycle();
    bus.req1_data = 16'h6001;
    next_cycle();
    bus.req1_data = 16'h6002;
    @(negedge clk);
    chk("mid_pre", {15'd0, bus.grant, bus.out_valid, bus.out_data}, {15'd0, 2'b11, 16'h6001});
    rst_n = 1'b0;
    #1;
    chk("mid_reset", outs(), 32'd0);
    bus.req0_valid = 1; bus.req0_data = 16'h7000;
    next_cycle();
    rst_n = 1'b1;
    m_owner = -1;
    next_cycle();
    @(negedge clk);
    chk("mid_tie", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd2);
    next_cycle();

    // randomized traffic against the reference model
    do_reset();
    pv[0] = 0; pv[1] = 0;
    dw[0] = 16'($urandom); dw[1] = 16'($urandom);
    for (int c = 0; c < 1500; c++) begin
      for (int n = 0; n < 2; n++)
        if (!pv[n] && $urandom_range(0, 3) != 0) pv[n] = 1;
      bus.req0_valid = pv[0];
      bus.req1_valid = pv[1];
      bus.req0_data  = pv[0] ? dw[0] : 16'($urandom);
      bus.req1_data  = pv[1] ? dw[1] : 16'($urandom);
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      can_load = !m_ov || bus.out_ready;
      er0 = (m_owner == 0) && can_load;
      er1 = (m_owner == 1) && can_load;
      eg  = (m_owner == 1);
      @(negedge clk);
      chk($sformatf("rand_c%0d", c), outs(), {11'd0, er0, er1, eg, m_ov, m_os, m_od});

      o = m_owner;
      beat = (o >= 0) && can_load && pv[o];
      if (beat) begin
        m_od = dw[o]; m_os = o[0]; m_ov = 1;
      end else if (bus.out_ready) begin
        m_ov = 0;
      end
      if (can_load) begin
        if (o < 0) begin
          if (pv[0] && pv[1]) m_owner = (m_last == 1) ? 0 : 1;
          else if (pv[0])     m_owner = 0;
          else if (pv[1])     m_owner = 1;
        end else if (!pv[o]) begin
          m_last = o; m_run = 0;
          m_owner = pv[1-o] ? 1 - o : -1;
        end else begin
          m_run++;
          if (m_run == MB) begin
            m_run = 0;
            if (pv[1-o]) begin
              m_last = o; m_owner = 1 - o;
            end
          end
        end
      end
      if (beat) begin
        pv[o] = 0; dw[o] = 16'($urandom);
      end
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
